rf68000_irq_dispatch: RTL

RF68000_IRQ_DISPATCH -- requirements
Module: rf68000_irq_dispatch

---
 rtl/rf68000_pkg.sv | 28 ++
 rtl/rf68000_irq_qual.sv | 36 +++
 rtl/rf68000_irq_dispatch.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rf68000_pkg.sv
// Shared definitions for the rf68000 interrupt dispatch path.
package rf68000_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2,
    WAIT = 2'd3
  } irq_state_e;

  localparam logic [7:0] SPUR_VEC     = 8'h18;
  localparam logic [7:0] AUTOVEC_BASE = 8'h18;
  localparam logic [7:0] NMI_CAUSE    = 8'h00;

  // Vector for an IACK of level adr against the latched request.
  // An IPL mismatch is spurious. A zero cause selects the autovector.
  function automatic logic [7:0] iack_vec(input logic [2:0] adr,
                                          input logic [2:0] lvl,
                                          input logic [7:0] cause,
                                          input logic [7:0] spur);
    logic [7:0] v;
    if (adr != lvl)           v = spur;
    else if (cause != 8'h00)  v = cause;
    else                      v = AUTOVEC_BASE + {5'd0, lvl};
    return v;
  endfunction

endpackage

// File: rtl/rf68000_irq_qual.sv
// Request qualifier: core match / NMI broadcast, level clamp, and
// the priority test against the level already pending.
module rf68000_irq_qual
  import rf68000_pkg::*;
#(
  parameter logic [5:0] CORE_ID = 6'd0
) (
  input  logic [3:0] irq_i,
  input  logic [7:0] cause_i,
  input  logic [5:0] core_i,
  input  logic       nmi_i,
  input  logic       nmi_taken,
  input  logic       pend,
  input  logic [2:0] cur_lvl,
  output logic       take,
  output logic       take_nmi,
  output logic [2:0] new_lvl,
  output logic [7:0] new_cause
);

  logic nmi_eff;
  logic hit;

  // An NMI that is already being serviced stays masked until it drops.
  // A new request is taken from idle if nonzero, or while pending only
  // if it is strictly higher than the latched level.
  always_comb begin
    nmi_eff   = nmi_i & ~nmi_taken;
    hit       = nmi_eff | (core_i == CORE_ID);
    new_lvl   = nmi_eff ? 3'd7 : (irq_i[3] ? 3'd7 : irq_i[2:0]);
    new_cause = nmi_eff ? NMI_CAUSE : cause_i;
    take      = hit && (new_lvl != 3'd0) && (!pend || (new_lvl > cur_lvl));
    take_nmi  = take & nmi_eff;
  end

endmodule

// File: rtl/rf68000_irq_dispatch.sv
// Per-core interrupt dispatcher: latches the highest qualified request,
// drives the IPL to the core, and answers the IACK bus cycle with a
// vector, retiring the cause with a one-cycle EOI pulse.
module rf68000_irq_dispatch #(
  parameter logic [5:0] CORE_ID  = 6'd0,
  parameter logic [7:0] SPUR_VEC = rf68000_pkg::SPUR_VEC
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] irq_i,
  input  logic [7:0] cause_i,
  input  logic [5:0] core_i,
  input  logic       nmi_i,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic       iack_i,
  input  logic [2:0] adr_i,
  output logic       ack_o,
  output logic [7:0] vec_o,
  output logic [2:0] ipl_o,
  output logic       eoi_o,
  output logic [7:0] eoi_cause_o
);
  import rf68000_pkg::*;

  irq_state_e state, state_n;
  logic [2:0] lvl, lvl_n;
  logic [7:0] cause, cause_n;
  logic       nmi_taken, nmi_taken_n;
  logic [2:0] ipl_n;
  logic       ack_n, eoi_n;
  logic [7:0] vec_n, eoi_cause_n;

  logic       bus, iack_cyc;
  logic       take, take_nmi;
  logic [2:0] q_lvl;
  logic [7:0] q_cause;

  rf68000_irq_qual #(.CORE_ID(CORE_ID)) u_qual (
    .irq_i     (irq_i),
    .cause_i   (cause_i),
    .core_i    (core_i),
    .nmi_i     (nmi_i),
    .nmi_taken (nmi_taken),
    .pend      (state == PEND),
    .cur_lvl   (lvl),
    .take      (take),
    .take_nmi  (take_nmi),
    .new_lvl   (q_lvl),
    .new_cause (q_cause)
  );

  // Next-state and registered-output logic. Outputs are all registered
  // so that ack/ipl/eoi come out one cycle after the sampled inputs.
  always_comb begin
    bus         = cyc_i & stb_i;
    iack_cyc    = bus & iack_i;
    state_n     = state;
    lvl_n       = lvl;
    cause_n     = cause;
    ipl_n       = ipl_o;
    ack_n       = 1'b0;
    vec_n       = 8'h00;
    eoi_n       = 1'b0;
    eoi_cause_n = 8'h00;
    nmi_taken_n = nmi_taken & nmi_i;   // edge latch re-arms when NMI drops
    case (state)
      IDLE: begin
        if (iack_cyc) begin
          // nothing pending: answer spurious, no EOI
          state_n = ACK;
          ack_n   = 1'b1;
          vec_n   = SPUR_VEC;
        end else if (take) begin
          state_n = PEND;
          lvl_n   = q_lvl;
          cause_n = q_cause;
          ipl_n   = q_lvl;
          if (take_nmi) nmi_taken_n = 1'b1;
        end
      end
      PEND: begin
        if (iack_cyc) begin
          state_n = ACK;
          ack_n   = 1'b1;
          vec_n   = iack_vec(adr_i, lvl, cause, SPUR_VEC);
          ipl_n   = 3'd0;
          if (adr_i == lvl) begin
            eoi_n       = 1'b1;
            eoi_cause_n = cause;
          end
        end else if (take) begin
          lvl_n   = q_lvl;
          cause_n = q_cause;
          ipl_n   = q_lvl;
          if (take_nmi) nmi_taken_n = 1'b1;
        end
      end
      ACK: begin
        if (bus) begin
          ack_n = 1'b1;
          vec_n = vec_o;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: state_n = IDLE;   // lets the controller's registered irq_i update
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      lvl         <= 3'd0;
      cause       <= 8'h00;
      nmi_taken   <= 1'b0;
      ipl_o       <= 3'd0;
      ack_o       <= 1'b0;
      vec_o       <= 8'h00;
      eoi_o       <= 1'b0;
      eoi_cause_o <= 8'h00;
    end else begin
      state       <= state_n;
      lvl         <= lvl_n;
      cause       <= cause_n;
      nmi_taken   <= nmi_taken_n;
      ipl_o       <= ipl_n;
      ack_o       <= ack_n;
      vec_o       <= vec_n;
      eoi_o       <= eoi_n;
      eoi_cause_o <= eoi_cause_n;
    end
  end

endmodule
